// File: rtl/switch_egress_arbiter_if.sv
// Bundle between the ingress buffers, the arbiter and the egress MAC.
// A beat moves on a cycle where valid and ready are both high; valid holds its beat stable until then; ready may depend combinationally on valid.
interface switch_egress_arbiter_if #(
    parameter int g_DEVICES    = 4,
    parameter int g_DATA_WIDTH = 32
);
    logic [g_DEVICES-1:0]              i_valid;
    logic [g_DEVICES-1:0]              i_sop;
    logic [g_DEVICES-1:0]              i_eop;
    logic [g_DEVICES*g_DATA_WIDTH-1:0] i_data;
    logic [g_DEVICES-1:0]              o_ready;
    logic                              o_valid;
    logic                              o_sop;
    logic                              o_eop;
    logic [g_DATA_WIDTH-1:0]           o_data;
    logic                              i_ready;
    logic [g_DEVICES-1:0]              o_grant;
    logic                              o_pktDone;
    logic                              o_truncated;
    logic                              o_sopError;
    logic [1:0]                        o_state;

    // master is the arbiter itself; slave is the surrounding ingress/egress side.
    modport master (
        input  i_valid, i_sop, i_eop, i_data, i_ready,
        output o_ready, o_valid, o_sop, o_eop, o_data,
        output o_grant, o_pktDone, o_truncated, o_sopError, o_state
    );
    modport slave (
        output i_valid, i_sop, i_eop, i_data, i_ready,
        input  o_ready, o_valid, o_sop, o_eop, o_data,
        input  o_grant, o_pktDone, o_truncated, o_sopError, o_state
    );
endinterface

// File: rtl/switch_egress_arbiter.sv
// Round-robin packet arbiter for one egress port: grants whole packets, truncates
// packets longer than g_MAX_BEATS and drains their tail. o_state: 0 IDLE, 1 LOCKED, 2 DRAIN.
module switch_egress_arbiter #(
    parameter int g_DEVICES    = 4,
    parameter int g_DATA_WIDTH = 32,
    parameter int g_MAX_BEATS  = 375
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    switch_egress_arbiter_if.master bus
);
    localparam int IW = $clog2(g_DEVICES);
    localparam int CW = $clog2(g_MAX_BEATS + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t               state_q;
    logic [g_DEVICES-1:0] grant_q;
    logic [IW-1:0]        rr_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic                 pkt_done_q;
    logic                 trunc_q;
    logic                 sop_err_q;

    logic [g_DEVICES-1:0] cand;
    logic                 win_found;
    logic [IW-1:0]        win_idx;
    logic [g_DEVICES-1:0] win_onehot;
    logic [IW-1:0]        g_idx;
    logic                 g_valid;
    logic                 g_eop;
    logic                 at_limit;
    logic                 xfer;

    // Winner is the first SOP requester strictly after the last owner.
    always_comb begin
        cand       = bus.i_valid & bus.i_sop;
        win_found  = 1'b0;
        win_idx    = '0;
        for (int k = 1; k <= g_DEVICES; k++) begin
            if (!win_found && cand[(int'(rr_q) + k) % g_DEVICES]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(rr_q) + k) % g_DEVICES);
            end
        end
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
    end

    always_comb begin
        g_idx = '0;
        for (int n = 0; n < g_DEVICES; n++) begin
            if (grant_q[n]) g_idx = IW'(n);
        end
    end

    assign g_valid  = bus.i_valid[g_idx];
    assign g_eop    = bus.i_eop[g_idx];
    assign at_limit = (cnt_q == CW'(g_MAX_BEATS - 1));
    assign cnt_d    = cnt_q + CW'(1);

    always_comb begin
        bus.o_valid = (state_q == ST_LOCKED) & g_valid;
        bus.o_sop   = (state_q == ST_LOCKED) & bus.i_sop[g_idx];
        bus.o_eop   = (state_q == ST_LOCKED) & (g_eop | at_limit);
        bus.o_data  = (state_q == ST_LOCKED) ?
                      bus.i_data[int'(g_idx)*g_DATA_WIDTH +: g_DATA_WIDTH] : '0;
        // In IDLE, stray non-SOP beats are swallowed; SOP requesters wait for a grant.
        case (state_q)
            ST_IDLE:   bus.o_ready = bus.i_valid & ~bus.i_sop;
            ST_LOCKED: bus.o_ready = grant_q & {g_DEVICES{bus.i_ready}};
            ST_DRAIN:  bus.o_ready = grant_q;
            default:   bus.o_ready = '0;
        endcase
    end

    assign xfer            = bus.o_valid & bus.i_ready;
    assign bus.o_grant     = grant_q;
    assign bus.o_pktDone   = pkt_done_q;
    assign bus.o_truncated = trunc_q;
    assign bus.o_sopError  = sop_err_q;
    assign bus.o_state     = state_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_q       <= IW'(g_DEVICES - 1);
            cnt_q      <= '0;
            pkt_done_q <= 1'b0;
            trunc_q    <= 1'b0;
            sop_err_q  <= 1'b0;
        end else begin
            pkt_done_q <= 1'b0;
            trunc_q    <= 1'b0;
            sop_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    sop_err_q <= |(bus.i_valid & ~bus.i_sop);
                    if (win_found) begin
                        grant_q <= win_onehot;
                        state_q <= ST_LOCKED;
                        cnt_q   <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (xfer) begin
                        cnt_q <= cnt_d;
                        if (g_eop) begin
                            state_q    <= ST_IDLE;
                            rr_q       <= g_idx;
                            grant_q    <= '0;
                            pkt_done_q <= 1'b1;
                        end else if (at_limit) begin
                            state_q <= ST_DRAIN;
                            trunc_q <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (g_valid && g_eop) begin
                        state_q <= ST_IDLE;
                        rr_q    <= g_idx;
                        grant_q <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_switch_egress_arbiter.sv
// Scoreboard bench for switch_egress_arbiter with g_MAX_BEATS=4 so truncation is reachable.
module tb_switch_egress_arbiter;
    localparam int D    = 4;
    localparam int W    = 32;
    localparam int MAXB = 4;
    localparam int EW   = D + 2 + W;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    switch_egress_arbiter_if #(.g_DEVICES(D), .g_DATA_WIDTH(W)) bus ();

    switch_egress_arbiter #(
        .g_DEVICES(D), .g_DATA_WIDTH(W), .g_MAX_BEATS(MAXB)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    // Expected egress beats: {grant one-hot, sop, eop, data}.
    logic [EW-1:0] exp_q[$];
    // Per-port source beats: {sop, eop, data}.
    logic [W+1:0]  src_q[D][$];

    int ready_mode;
    bit ready_phase;
    int n_done, n_trunc, n_serr, n_valid, n_b2b, n_leak;
    bit prev_valid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [D-1:0] onehot(input int p);
        logic [D-1:0] r;
        r    = '0;
        r[p] = 1'b1;
        return r;
    endfunction

    function automatic int pending();
        int s;
        s = 0;
        for (int n = 0; n < D; n++) s += src_q[n].size();
        return s;
    endfunction

    task automatic clear_counts();
        n_done = 0; n_trunc = 0; n_serr = 0; n_valid = 0; n_b2b = 0; n_leak = 0;
        prev_valid = 1'b0;
    endtask

    task automatic drive_inputs();
        logic [D-1:0]   v, s, e;
        logic [D*W-1:0] d;
        logic [W+1:0]   head;
        v = '0; s = '0; e = '0; d = '0;
        for (int n = 0; n < D; n++) begin
            if (src_q[n].size() > 0) begin
                head       = src_q[n][0];
                v[n]       = 1'b1;
                s[n]       = head[W+1];
                e[n]       = head[W];
                d[n*W +: W] = head[W-1:0];
            end
        end
        bus.i_valid = v;
        bus.i_sop   = s;
        bus.i_eop   = e;
        bus.i_data  = d;
        case (ready_mode)
            1: begin
                bus.i_ready = ready_phase;
                ready_phase = ~ready_phase;
            end
            2:       bus.i_ready = 1'($urandom_range(0, 1));
            default: bus.i_ready = 1'b1;
        endcase
    endtask

    task automatic send_pkt(input int port, input int len);
        logic [W-1:0] d;
        logic         sop, eop;
        for (int b = 0; b < len; b++) begin
            d   = $urandom();
            sop = (b == 0);
            eop = (b == len - 1);
            src_q[port].push_back({sop, eop, d});
            if (b < MAXB) exp_q.push_back({onehot(port), sop, eop | (b == MAXB - 1), d});
        end
    endtask

    task automatic monitor();
        logic [EW-1:0] got, e;
        if (bus.o_pktDone)   n_done++;
        if (bus.o_truncated) n_trunc++;
        if (bus.o_sopError)  n_serr++;
        if (bus.o_valid)     n_valid++;
        if (bus.o_valid && prev_valid) n_b2b++;
        prev_valid = bus.o_valid;
        if (bus.o_valid && bus.i_ready) begin
            got = {bus.o_grant, bus.o_sop, bus.o_eop, bus.o_data};
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(got), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("beat", 64'(got), 64'(e));
            end
        end
        if (bus.o_state == 2'd1 && bus.o_ready !== (bus.i_ready ? bus.o_grant : '0)) n_leak++;
        if (bus.o_grant != '0 && (bus.o_ready & ~bus.o_grant) != '0) n_leak++;
    endtask

    task automatic step();
        logic [D-1:0] acc;
        logic [W+1:0] tmp;
        @(negedge clk);
        monitor();
        acc = bus.i_valid & bus.o_ready;
        @(posedge clk);
        #1;
        for (int n = 0; n < D; n++) begin
            if (acc[n] && src_q[n].size() > 0) tmp = src_q[n].pop_front();
        end
        drive_inputs();
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) step();
    endtask

    task automatic run(input int budget, output int steps);
        drive_inputs();
        steps = 0;
        while ((exp_q.size() != 0 || pending() != 0) && steps < budget) begin
            step();
            steps++;
        end
        check("drain_within_budget", 64'(exp_q.size() + pending()), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int n = 0; n < D; n++) src_q[n].delete();
        exp_q.delete();
        ready_mode  = 0;
        ready_phase = 1'b1;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive_inputs();
        clear_counts();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_flags"}, 64'({bus.o_valid, bus.o_sop, bus.o_eop,
                                    bus.o_pktDone, bus.o_truncated, bus.o_sopError}), 64'(0));
        check({tag, "_data"},  64'(bus.o_data),  64'(0));
        check({tag, "_ready"}, 64'(bus.o_ready), 64'(0));
        check({tag, "_grant"}, 64'(bus.o_grant), 64'(0));
        check({tag, "_state"}, 64'(bus.o_state), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int steps;
        logic [W+1:0] stray;

        // Reset state
        do_reset();
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;

        // Ports 0 and 2 together: 0 first, one bubble per grant
        send_pkt(0, 3);
        send_pkt(2, 3);
        run(100, steps);
        check("t1_cycles", 64'(steps), 64'(8));
        settle(2);
        check("t1_pktdone", 64'(n_done), 64'(2));
        check("t1_trunc", 64'(n_trunc), 64'(0));

        // All ports requesting single-beat packets: 0,1,2,3,0,1,2,3
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < D; p++) send_pkt(p, 1);
        run(100, steps);
        check("t2_cycles", 64'(steps), 64'(16));
        check("t2_valid_cycles", 64'(n_valid), 64'(8));
        check("t2_back_to_back", 64'(n_b2b), 64'(0));

        // Toggling egress ready, packet exactly g_MAX_BEATS long
        do_reset();
        ready_mode  = 1;
        ready_phase = 1'b1;
        send_pkt(1, MAXB);
        run(100, steps);
        settle(2);
        check("t3_pktdone", 64'(n_done), 64'(1));
        check("t3_trunc", 64'(n_trunc), 64'(0));
        check("t3_ready_leak", 64'(n_leak), 64'(0));

        // Random egress ready over a series of short packets
        ready_mode = 2;
        for (int i = 0; i < 6; i++) begin
            send_pkt(int'($urandom_range(0, D - 1)), int'($urandom_range(1, MAXB)));
            run(200, steps);
        end
        settle(2);
        check("t3r_pktdone", 64'(n_done), 64'(7));
        check("t3r_trunc", 64'(n_trunc), 64'(0));
        check("t3r_ready_leak", 64'(n_leak), 64'(0));

        // 7-beat packet truncated at 4, tail drained
        do_reset();
        send_pkt(3, 7);
        run(100, steps);
        check("t4_cycles", 64'(steps), 64'(8));
        settle(2);
        check("t4_trunc", 64'(n_trunc), 64'(1));
        check("t4_pktdone", 64'(n_done), 64'(0));
        check("t4_state_idle", 64'(bus.o_state), 64'(0));
        clear_counts();
        send_pkt(0, 1);
        send_pkt(1, 1);
        run(100, steps);
        settle(2);
        check("t4_next_pktdone", 64'(n_done), 64'(2));

        // Non-SOP beat in IDLE is swallowed
        do_reset();
        stray = {1'b0, 1'b0, 32'hDEAD_BEEF};
        src_q[1].push_back(stray);
        run(20, steps);
        check("t5_accept_cycles", 64'(steps), 64'(1));
        settle(2);
        check("t5_soperror", 64'(n_serr), 64'(1));
        check("t5_valid_cycles", 64'(n_valid), 64'(0));

        // Reset on beat 2 of 4
        do_reset();
        send_pkt(0, 4);
        drive_inputs();
        steps = 0;
        while (exp_q.size() > 3 && steps < 10) begin
            step();
            steps++;
        end
        check("t6_first_beat", 64'(exp_q.size()), 64'(3));
        rst = 1'b1;
        step();
        rst = 1'b0;
        src_q[0].delete();
        exp_q.delete();
        drive_inputs();
        @(negedge clk);
        check_idle("t6_after_reset");
        @(posedge clk);
        #1;
        clear_counts();
        send_pkt(0, 2);
        run(100, steps);
        check("t6_regrant_cycles", 64'(steps), 64'(3));
        settle(2);
        check("t6_pktdone", 64'(n_done), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
